control_unit_mc: RTL and testbench
==================================

// Module: control_unit_mc
// PURPOSE
//  Multicycle control FSM for the RV32I subset lw, sw, R-type, I-type ALU, beq and jal.
//  Consumes the datapath decode fields (op, f3, f7, zero) and drives one cycle of datapath
//  controls per state.
//  Sits beside the multicycle datapath variant: instruction register, old-PC, ALUOut and
//  data registers, single shared memory.
// PARAMETERS
//  ALUCTRL_W   3   width of aluControl (encodings: add 000, sub 001, and 010, or 011, slt 101)
//  STATE_W     4   width of state register / debug port
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-low reset (0 = reset)
//  op          in   7   instruction[6:0] from instruction register
//  f3          in   3   instruction[14:12]
//  f7          in   7   instruction[31:25]
//  zero        in   1   ALU zero flag; datapath zero[0] connects here
//  pcWrite     out  1   PC load enable
//  adrSrc      out  1   memory address: 0 = PC, 1 = ALUOut/result
//  memWrite    out  1   memory write enable
//  irWrite     out  1   instruction-register and old-PC load enable
//  resultSrc   out  2   00 = ALUOut, 01 = read data, 10 = ALU result direct
//  aluSrcA     out  2   00 = PC, 01 = oldPC, 10 = rd1 (A register)
//  aluSrcB     out  2   00 = rd2 (B register), 01 = immExt, 10 = constant 4
//  immSrc      out  2   00 = I, 01 = S, 10 = B, 11 = J (combinational from op, every state)
//  regWrite    out  1   register-bank write enable
//  aluControl  out  3   ALU operation
//  illegalOp   out  1   one-cycle pulse: unsupported opcode seen in DECODE
//  state       out  4   current state code, debug only
// BEHAVIOUR
//  - Moore FSM. Outputs are a function of state only, except:
//    - pcWrite = pcUpdate | (branch & zero);
//    - aluControl also depends on op, f3, f7.
//  - State codes and per-state outputs (unlisted outputs = 0):
//    - FETCH 0: adrSrc 0, irWrite 1, aluSrcA 00, aluSrcB 10, aluOp add, resultSrc 10, pcUpdate 1
//    - DECODE 1: aluSrcA 01, aluSrcB 01, aluOp add (branch/jump target into ALUOut)
//    - MEMADR 2: aluSrcA 10, aluSrcB 01, aluOp add
//    - MEMREAD 3: resultSrc 00, adrSrc 1
//    - MEMWB 4: resultSrc 01, regWrite 1
//    - MEMWRITE 5: resultSrc 00, adrSrc 1, memWrite 1
//    - EXECUTER 6: aluSrcA 10, aluSrcB 00, aluOp funct
//    - EXECUTEI 7: aluSrcA 10, aluSrcB 01, aluOp funct
//    - ALUWB 8: resultSrc 00, regWrite 1
//    - JAL 9: aluSrcA 01, aluSrcB 10, aluOp add, resultSrc 00, pcUpdate 1
//    - BEQ 10: aluSrcA 10, aluSrcB 00, aluOp sub, resultSrc 00, branch 1
//  - Transitions:
//    - FETCH -> DECODE.
//    - DECODE, by op:
//      - 0000011 or 0100011 -> MEMADR
//      - 0110011 -> EXECUTER
//      - 0010011 -> EXECUTEI
//      - 1101111 -> JAL
//      - 1100011 -> BEQ
//      - any other op -> FETCH, with illegalOp = 1 for that DECODE cycle
//    - MEMADR -> MEMREAD if op = lw, else MEMWRITE.
//    - MEMREAD -> MEMWB.
//    - EXECUTER, EXECUTEI, JAL -> ALUWB.
//    - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
//  - Cycles per instruction (FETCH to next FETCH): lw 5, sw 4, R 4, I 4, jal 4, beq 3.
//  - ALU decode:
//    - aluOp add -> 000; aluOp sub -> 001.
//    - aluOp funct:
//      - f3 000: sub (001) if op[5] & f7[5], else add (000); addi is never sub.
//      - f3 010 -> 101; f3 110 -> 011; f3 111 -> 010.
//      - Any other f3 -> 000.
//  - Reset:
//    - reset = 0 forces state = FETCH asynchronously.
//    - While reset = 0: pcWrite, memWrite, irWrite, regWrite and illegalOp are forced to 0;
//      the remaining outputs show FETCH values.
//    - First FETCH executes on the first rising edge after reset deasserts.
//  - Reset mid-instruction aborts it: no partial regWrite or memWrite after the reset edge.
//  - Unreachable state codes 11-15 -> FETCH on the next edge; all enables 0 while in them.
//  - BEQ with zero = 0: pcWrite = 0; PC keeps the PC+4 loaded in FETCH.
//  - zero is sampled combinationally only in BEQ and ignored in every other state.
// STRUCTURE
//  - Shared header ctrl_defs.vh, included by this block and the datapath, holds:
//    - opcode constants;
//    - state codes;
//    - aluControl, aluOp, immSrc, resultSrc, aluSrcA and aluSrcB encodings.
//  - One combinational sub-module, alu_decoder (aluOp, f3, op5, f7_5 -> aluControl), is natural.
//  - FSM next-state logic, state register and output decode stay in this module.
//  - immSrc is a combinational decode inside this module.
// TESTING
//  1. reset = 0 held 3 cycles, then released:
//     state = 0, all enables 0 during reset; first edge after release gives state 1.
//  2. lw (op 0000011): states 0,1,2,3,4,0.
//     regWrite = 1 only in state 4 with resultSrc 01; adrSrc = 1 in state 3.
//  3. sw (0100011): states 0,1,2,5,0; memWrite = 1 exactly one cycle; regWrite never set.
//  4. R-type with f3 000, f7 0100000: state 6 drives aluControl 001.
//     addi (0010011, f3 000, f7 0100000): state 7 drives 000.
//     or: 011; and: 010; slt: 101.
//  5. beq: zero = 1 in state 10 -> pcWrite = 1; zero = 0 -> pcWrite = 0; both return to state 0.
//     jal: states 0,1,9,8,0 with pcWrite = 1 in state 9.
//  6. Illegal op 1111111 gives illegalOp pulse in state 1, then state 0.
//     reset asserted during state 3 -> state 0 immediately, no regWrite afterwards.

Source files
------------

// File: rtl/control_unit_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit_mc_pkg
//  Purpose  : Shared encodings for the multicycle RV32I control unit and its
//             datapath: opcodes, FSM state codes, ALU operation/control codes
//             and datapath mux select encodings. Also provides the immSrc
//             decode helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package control_unit_mc_pkg;

   // Opcodes (instruction[6:0])
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // FSM state codes; 11..15 are unreachable
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   // Operation class requested by the FSM from the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   // aluControl encodings
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // immSrc encodings
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // resultSrc encodings
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // aluSrcA encodings
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   // aluSrcB encodings
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Immediate format from opcode; formats without an immediate fall back to I
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   imm_src_of = IMM_S;
         OP_BEQ:  imm_src_of = IMM_B;
         OP_JAL:  imm_src_of = IMM_J;
         default: imm_src_of = IMM_I;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_mc_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit_mc_alu_decoder
//  Purpose  : Combinational ALU decoder. Maps the FSM's operation class plus
//             funct fields to the 3-bit aluControl code.
//  Ports    : alu_op      in  2  operation class (add / sub / funct)
//             f3          in  3  instruction[14:12]
//             op5         in  1  instruction[5] (1 = R-type, 0 = I-type)
//             f7_5        in  1  instruction[30]
//             alu_control out 3  ALU operation code
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit_mc_alu_decoder
   import control_unit_mc_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] f3,
   input  logic       op5,
   input  logic       f7_5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (f3)
               // op5 separates R-type from addi, whose f7 field is immediate bits
               3'b000:  alu_control = (op5 & f7_5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/control_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit_mc
//  Purpose  : Multicycle control FSM for RV32I lw, sw, R-type, I-type ALU,
//             beq and jal. Drives one cycle of datapath controls per state.
//  Ports    : clk, reset (async, active-low)
//             op/f3/f7/zero          decode fields and ALU zero flag
//             pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA,
//             aluSrcB, immSrc, regWrite, aluControl  datapath controls
//             illegalOp              pulse for an unsupported opcode in DECODE
//             state                  current state code (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit_mc
   import control_unit_mc_pkg::*;
#(
   parameter int ALUCTRL_W = 3,
   parameter int STATE_W   = 4
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           f3,
   input  logic [6:0]           f7,
   input  logic                 zero,
   output logic                 pcWrite,
   output logic                 adrSrc,
   output logic                 memWrite,
   output logic                 irWrite,
   output logic [1:0]           resultSrc,
   output logic [1:0]           aluSrcA,
   output logic [1:0]           aluSrcB,
   output logic [1:0]           immSrc,
   output logic                 regWrite,
   output logic [ALUCTRL_W-1:0] aluControl,
   output logic                 illegalOp,
   output logic [STATE_W-1:0]   state
);

   state_t     cur_state;
   logic       legal_op;
   logic       pc_update;
   logic       branch;
   logic       mem_write_s;
   logic       ir_write_s;
   logic       reg_write_s;
   logic [1:0] alu_op;
   logic [2:0] alu_ctrl;
   logic       unused_f7;

   assign unused_f7 = ^{f7[6], f7[4:0]};

   always_comb begin
      case (op)
         OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: legal_op = 1'b1;
         default:                                  legal_op = 1'b0;
      endcase
   end

   // State register and next-state logic
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_state <= S_FETCH;
      end else begin
         case (cur_state)
            S_FETCH:  cur_state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: cur_state <= S_MEMADR;
                  OP_R:         cur_state <= S_EXECUTER;
                  OP_I:         cur_state <= S_EXECUTEI;
                  OP_JAL:       cur_state <= S_JAL;
                  OP_BEQ:       cur_state <= S_BEQ;
                  default:      cur_state <= S_FETCH;
               endcase
            end
            S_MEMADR:   cur_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  cur_state <= S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI,
            S_JAL:      cur_state <= S_ALUWB;
            default:    cur_state <= S_FETCH;
         endcase
      end
   end

   // Moore output decode; unreachable codes leave every enable at zero
   always_comb begin
      pc_update   = 1'b0;
      branch      = 1'b0;
      adrSrc      = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      resultSrc   = RES_ALUOUT;
      aluSrcA     = SRCA_PC;
      aluSrcB     = SRCB_RD2;
      alu_op      = ALUOP_ADD;
      case (cur_state)
         S_FETCH: begin
            ir_write_s = 1'b1;
            aluSrcB    = SRCB_FOUR;
            resultSrc  = RES_ALU;
            pc_update  = 1'b1;
         end
         S_DECODE: begin
            aluSrcA = SRCA_OLDPC;
            aluSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            aluSrcA = SRCA_RD1;
            aluSrcB = SRCB_IMM;
         end
         S_MEMREAD: adrSrc = 1'b1;
         S_MEMWB: begin
            resultSrc   = RES_DATA;
            reg_write_s = 1'b1;
         end
         S_MEMWRITE: begin
            adrSrc      = 1'b1;
            mem_write_s = 1'b1;
         end
         S_EXECUTER: begin
            aluSrcA = SRCA_RD1;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            aluSrcA = SRCA_RD1;
            aluSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: reg_write_s = 1'b1;
         S_JAL: begin
            aluSrcA   = SRCA_OLDPC;
            aluSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            aluSrcA = SRCA_RD1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   control_unit_mc_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .f3          (f3),
      .op5         (op[5]),
      .f7_5        (f7[5]),
      .alu_control (alu_ctrl)
   );

   // Enables are gated by reset so nothing writes while reset is held,
   // including the cycle in which reset lands mid-instruction.
   assign pcWrite    = reset & (pc_update | (branch & zero));
   assign memWrite   = reset & mem_write_s;
   assign irWrite    = reset & ir_write_s;
   assign regWrite   = reset & reg_write_s;
   assign illegalOp  = reset & (cur_state == S_DECODE) & ~legal_op;
   assign immSrc     = imm_src_of(op);
   assign aluControl = ALUCTRL_W'(alu_ctrl);
   assign state      = STATE_W'(cur_state);

endmodule
`default_nettype wire

// File: tb/tb_control_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit_mc
//  Purpose  : Scoreboard testbench for control_unit_mc. The stimulus process
//             pushes one expected output vector per clock cycle; a monitor
//             samples the DUT on the falling edge and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit_mc;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       zero;
   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegalOp;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
   logic [2:0] aluControl;
   logic [3:0] state;

   always #5 clk = ~clk;

   control_unit_mc dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .f3         (f3),
      .f7         (f7),
      .zero       (zero),
      .pcWrite    (pcWrite),
      .adrSrc     (adrSrc),
      .memWrite   (memWrite),
      .irWrite    (irWrite),
      .resultSrc  (resultSrc),
      .aluSrcA    (aluSrcA),
      .aluSrcB    (aluSrcB),
      .immSrc     (immSrc),
      .regWrite   (regWrite),
      .aluControl (aluControl),
      .illegalOp  (illegalOp),
      .state      (state)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic       rw;
      logic [2:0] alu;
      logic       ill;
   } vec_t;

   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Per-state output table; pcWrite, aluControl and illegalOp are given
   // explicitly by each caller.
   function automatic vec_t row(input logic [3:0] st, input logic [6:0] o,
                                input logic pcw, input logic [2:0] alu,
                                input logic ill);
      vec_t v;
      v     = '0;
      v.st  = st;
      v.pcw = pcw;
      v.alu = alu;
      v.ill = ill;
      case (o)
         SW:      v.imm = 2'b01;
         BEQ:     v.imm = 2'b10;
         JAL:     v.imm = 2'b11;
         default: v.imm = 2'b00;
      endcase
      case (st)
         4'd0:  begin v.irw = 1'b1; v.sb = 2'b10; v.rs = 2'b10; end
         4'd1:  begin v.sa = 2'b01; v.sb = 2'b01; end
         4'd2:  begin v.sa = 2'b10; v.sb = 2'b01; end
         4'd3:  v.adr = 1'b1;
         4'd4:  begin v.rs = 2'b01; v.rw = 1'b1; end
         4'd5:  begin v.adr = 1'b1; v.mw = 1'b1; end
         4'd6:  v.sa = 2'b10;
         4'd7:  begin v.sa = 2'b10; v.sb = 2'b01; end
         4'd8:  v.rw = 1'b1;
         4'd9:  begin v.sa = 2'b01; v.sb = 2'b10; end
         4'd10: v.sa = 2'b10;
         default: ;
      endcase
      return v;
   endfunction

   // While reset is low: FETCH mux values, all enables zero
   function automatic vec_t rst_row(input logic [6:0] o);
      vec_t v;
      v     = row(4'd0, o, 1'b0, 3'b000, 1'b0);
      v.irw = 1'b0;
      return v;
   endfunction

   task automatic set_in(input logic [6:0] o, input logic [2:0] ff3,
                         input logic [6:0] ff7, input logic z);
      op   = o;
      f3   = ff3;
      f7   = ff7;
      zero = z;
   endtask

   task automatic cyc(input vec_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor
   always @(negedge clk) begin
      vec_t e;
      vec_t a;
      if (exp_q.size() > 0) begin
         e     = exp_q.pop_front();
         a.st  = state;
         a.pcw = pcWrite;
         a.adr = adrSrc;
         a.mw  = memWrite;
         a.irw = irWrite;
         a.rs  = resultSrc;
         a.sa  = aluSrcA;
         a.sb  = aluSrcB;
         a.imm = immSrc;
         a.rw  = regWrite;
         a.alu = aluControl;
         a.ill = illegalOp;
         n_checks++;
         if (a.st !== e.st) begin
            n_fail++;
            $display("FAIL state @%0t: got %0d expected %0d", $time, a.st, e.st);
         end
         n_checks++;
         if (a[16:0] !== e[16:0]) begin
            n_fail++;
            $display("FAIL controls @%0t state %0d: got pcw%b adr%b mw%b irw%b rs%b sa%b sb%b imm%b rw%b alu%b ill%b expected pcw%b adr%b mw%b irw%b rs%b sa%b sb%b imm%b rw%b alu%b ill%b",
                     $time, e.st, a.pcw, a.adr, a.mw, a.irw, a.rs, a.sa, a.sb, a.imm, a.rw, a.alu, a.ill,
                     e.pcw, e.adr, e.mw, e.irw, e.rs, e.sa, e.sb, e.imm, e.rw, e.alu, e.ill);
         end
      end
   end

   initial begin
      reset = 1'b0;
      set_in(LW, 3'b010, 7'b0, 1'b0);
      @(posedge clk);
      #1;

      // Reset held three cycles
      repeat (3) cyc(rst_row(LW));
      reset = 1'b1;

      // lw: 0,1,2,3,4
      cyc(row(4'd0, LW, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, LW, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd2, LW, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd3, LW, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd4, LW, 1'b0, 3'b000, 1'b0));

      // sw: 0,1,2,5
      set_in(SW, 3'b010, 7'b0, 1'b0);
      cyc(row(4'd0, SW, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, SW, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd2, SW, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd5, SW, 1'b0, 3'b000, 1'b0));

      // sub: R-type f3 000 f7 0100000 -> 001
      set_in(RT, 3'b000, 7'b0100000, 1'b0);
      cyc(row(4'd0, RT, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, RT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd6, RT, 1'b0, 3'b001, 1'b0));
      cyc(row(4'd8, RT, 1'b0, 3'b000, 1'b0));

      // addi with f7 bit 5 set is still add
      set_in(IT, 3'b000, 7'b0100000, 1'b0);
      cyc(row(4'd0, IT, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, IT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd7, IT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd8, IT, 1'b0, 3'b000, 1'b0));

      // or / and / slt (R-type) and slti (I-type)
      set_in(RT, 3'b110, 7'b0, 1'b0);
      cyc(row(4'd0, RT, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, RT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd6, RT, 1'b0, 3'b011, 1'b0));
      cyc(row(4'd8, RT, 1'b0, 3'b000, 1'b0));
      set_in(RT, 3'b111, 7'b0, 1'b0);
      cyc(row(4'd0, RT, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, RT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd6, RT, 1'b0, 3'b010, 1'b0));
      cyc(row(4'd8, RT, 1'b0, 3'b000, 1'b0));
      set_in(RT, 3'b010, 7'b0, 1'b0);
      cyc(row(4'd0, RT, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, RT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd6, RT, 1'b0, 3'b101, 1'b0));
      cyc(row(4'd8, RT, 1'b0, 3'b000, 1'b0));
      set_in(IT, 3'b010, 7'b0, 1'b0);
      cyc(row(4'd0, IT, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, IT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd7, IT, 1'b0, 3'b101, 1'b0));
      cyc(row(4'd8, IT, 1'b0, 3'b000, 1'b0));

      // beq taken: zero high throughout, only BEQ reacts to it
      set_in(BEQ, 3'b000, 7'b0, 1'b1);
      cyc(row(4'd0, BEQ, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, BEQ, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd10, BEQ, 1'b1, 3'b001, 1'b0));

      // beq not taken
      set_in(BEQ, 3'b000, 7'b0, 1'b0);
      cyc(row(4'd0, BEQ, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, BEQ, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd10, BEQ, 1'b0, 3'b001, 1'b0));

      // jal: 0,1,9,8 with zero high (ignored outside BEQ)
      set_in(JAL, 3'b000, 7'b0, 1'b1);
      cyc(row(4'd0, JAL, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, JAL, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd9, JAL, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd8, JAL, 1'b0, 3'b000, 1'b0));

      // illegal opcode: pulse in DECODE then back to FETCH
      set_in(BAD, 3'b000, 7'b0, 1'b0);
      cyc(row(4'd0, BAD, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, BAD, 1'b0, 3'b000, 1'b1));
      set_in(SW, 3'b010, 7'b0, 1'b0);
      cyc(row(4'd0, SW, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, SW, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd2, SW, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd5, SW, 1'b0, 3'b000, 1'b0));

      // lw aborted by reset as it enters MEMREAD
      set_in(LW, 3'b010, 7'b0, 1'b0);
      cyc(row(4'd0, LW, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, LW, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd2, LW, 1'b0, 3'b000, 1'b0));
      reset = 1'b0;
      cyc(rst_row(LW));
      cyc(rst_row(LW));
      reset = 1'b1;
      // restart cleanly with an add
      set_in(RT, 3'b000, 7'b0, 1'b0);
      cyc(row(4'd0, RT, 1'b1, 3'b000, 1'b0));
      cyc(row(4'd1, RT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd6, RT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd8, RT, 1'b0, 3'b000, 1'b0));
      cyc(row(4'd0, RT, 1'b1, 3'b000, 1'b0));

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
